event_timestamper: RTL and testbench
====================================

// Module: event_timestamper
// PURPOSE
//  Consumes the free-running 64-bit ns Timer count and timestamps asynchronous external events.
//  Each enabled input channel is synchronised and edge-detected.
//  On a detected edge, the Timer value of that cycle is captured together with the channel number.
//  Records are buffered in a FIFO and presented on a valid/ready stream to downstream logic (CPU bridge, DMA).
// PARAMETERS
//  CHANNELS     4   number of event inputs (1..16)
//  FIFO_DEPTH   16  record FIFO depth; power of 2, >=4
//  SYNC_STAGES  2   synchroniser flops per channel (2..4)
// PORTS
//  Clk        in   1           system clock; same clock as the Timer source
//  Reset      in   1           synchronous, active-high reset
//  Timer      in   64          current time [ns] from the Timer block, registered in the Clk domain
//  Event      in   CHANNELS    asynchronous event pins
//  Enable     in   CHANNELS    per-channel detection enable
//  Rising     in   CHANNELS    per-channel edge select: 1 = rising, 0 = falling
//  ClrOvf     in   1           clears OvfCount (synchronous, 1-cycle pulse)
//  Ready      in   1           downstream accepts the record
//  Valid      out  1           record available
//  Stamp      out  64          record timestamp [ns]
//  Channel    out  clog2(CH)   record channel index (width 1 when CHANNELS=1)
//  Level      out  clog2(D)+1  FIFO fill level, 0..FIFO_DEPTH
//  OvfCount   out  16          dropped-event counter; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset values: Valid=0, Level=0, OvfCount=0; Stamp and Channel hold their reset content of 0.
//    Reset clears the synchroniser flops, edge history, pending flags, FIFO pointers and the arm counter.
//  Arming: detection is suppressed for SYNC_STAGES+1 cycles after Reset deasserts.
//    The edge history loads the synchronised level during this window.
//    Result: a pin already high at reset produces no event.
//  Edge detect: edge = Enable & (Rising ? sync & ~hist : ~sync & hist); hist <= sync every cycle.
//  Capture: on an edge, pend[ch] <= 1 and stamp[ch] <= Timer as sampled in that same cycle.
//    Pin-to-stamp offset is fixed at SYNC_STAGES+1 cycles; no compensation is applied.
//  Drop: an edge on a channel whose pend is still 1 is discarded.
//    The stored stamp is kept (oldest wins) and OvfCount increments by 1.
//    Several drops in one cycle add their count, saturating at 16'hFFFF.
//  Arbiter: each cycle, the lowest-index pending channel is written to the FIFO when space is free.
//    Space is free when not full, or when full with a pop in the same cycle.
//    Its pend clears on that write.
//    The same channel may re-pend in the same cycle if a new edge arrives, using the new stamp.
//    Simultaneous edges on N channels carry identical stamps and drain over N cycles in index order.
//  FIFO: first-word fall-through; Valid = (Level!=0).
//    Stamp/Channel reflect the head entry while Valid=1.
//    A pop occurs on Valid&Ready.
//    Push plus pop in the same cycle leaves Level unchanged.
//    Ready while Valid=0 is ignored.
//  Full: no FIFO writes occur; events accumulate in pend and overflow there, never inside the FIFO.
//  Enable: deasserting Enable stops new detections only; already pending records still drain.
//  ClrOvf with a simultaneous drop: OvfCount <= number of drops in that cycle.
//  Timer wrap (2^64-1 -> 0) is not treated specially; stamps are raw counts.
//  Reset mid-operation: all pending and FIFO content is discarded, and Valid=0 on the next cycle.
// STRUCTURE
//  Package timestamper_pkg:
//    stamp_t = logic[63:0]
//    record_t = struct {chan, stamp}
//    OVF_MAX = 16'hFFFF
//  Sub-module sync_fifo #(WIDTH, DEPTH): FWFT, synchronous active-high reset, full/empty/level outputs.
//  Top level holds the synchronisers, edge detect, pending registers, priority arbiter and OvfCount.
// TESTING (Clk 50 MHz, Timer += 20 per cycle)
//  1. Single rise on ch0 at Timer=1000 (sync done): one record, Channel=0, Stamp=1000, Level 0->1.
//  2. Rising on ch1 and ch3 in the same cycle with Timer=2000, Ready=1:
//     two records in order ch1 then ch3, both Stamp=2000, on consecutive cycles.
//  3. Ready=0, 20 edges on ch0 spaced 4 cycles apart with DEPTH=16:
//     Level=16; one pending record held; OvfCount=3.
//     After Ready=1, 17 records drain in time order.
//  4. Pin high through Reset, then a falling edge with Rising=0:
//     no record at arming; exactly one record on the falling edge.
//  5. Reset asserted with Level=5 and 2 channels pending: next cycle Valid=0, Level=0, OvfCount=0.
//     No records emerge afterwards.
//  6. Force OvfCount=16'hFFFE, then cause 3 drops: OvfCount=16'hFFFF.
//     ClrOvf pulse with 1 concurrent drop: OvfCount=1.

Source files
------------

// File: rtl/timestamper_pkg.sv
// Shared types for the event timestamper: timestamp, FIFO record and overflow limit.
// The record channel field is sized for the largest supported channel count (16).
package timestamper_pkg;

   typedef logic [63:0] stamp_t;

   localparam int CHAN_FIELD_W = 4;

   typedef struct packed {
      logic [CHAN_FIELD_W-1:0] chan;
      stamp_t                  stamp;
   } record_t;

   localparam logic [15:0] OVF_MAX = 16'hFFFF;

   function automatic int chan_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with synchronous active-high reset.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      level_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_reg == FULL_LEVEL);
   assign empty   = (level_reg == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (do_push && !do_pop)      level_reg <= level_reg + (AW + 1)'(1);
         else if (do_pop && !do_push) level_reg <= level_reg - (AW + 1)'(1);
      end
   end

   // Output forced to zero while empty so the head reads as 0 after reset.
   assign dout  = empty ? '0 : mem[rd_ptr_reg];
   assign level = level_reg;

endmodule

// File: rtl/event_timestamper.sv
// Timestamps edges on asynchronous event pins with the shared ns Timer and streams
// {channel, stamp} records out of a FIFO; edges that find their channel still pending are counted.
module event_timestamper
   import timestamper_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2,
   localparam int CH_W  = chan_width(CHANNELS),
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [63:0]         Timer,
   input  logic [CHANNELS-1:0] Event,
   input  logic [CHANNELS-1:0] Enable,
   input  logic [CHANNELS-1:0] Rising,
   input  logic                ClrOvf,
   input  logic                Ready,
   output logic                Valid,
   output logic [63:0]         Stamp,
   output logic [CH_W-1:0]     Channel,
   output logic [LVL_W-1:0]    Level,
   output logic [15:0]         OvfCount
);

   localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_reg;
   logic [CHANNELS-1:0] sync_lvl;
   logic [CHANNELS-1:0] hist_reg;
   logic [CHANNELS-1:0] edge_det;
   logic [CHANNELS-1:0] pend_reg;
   logic [CHANNELS-1:0] pend_next;
   logic [CHANNELS-1:0] grant_oh;
   logic [CHANNELS-1:0] drop_vec;
   logic [CHANNELS-1:0] load_vec;
   stamp_t              stamp_reg [CHANNELS];
   logic [2:0]          arm_reg;
   logic                armed;
   logic [15:0]         ovf_reg;
   logic [15:0]         ovf_next;
   logic [16:0]         ovf_sum;
   logic [4:0]          drop_cnt;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_pop;
   logic                space;
   logic                grant_any;
   record_t             wr_rec;
   record_t             head_rec;

   // Edge history tracks the synchronised level even while disarmed, so a pin
   // that is already high when reset releases never looks like a fresh edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync_reg <= '0;
         hist_reg <= '0;
         arm_reg  <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], Event};
         hist_reg <= sync_lvl;
         if (arm_reg != ARM_DONE) arm_reg <= arm_reg + 3'd1;
      end
   end

   assign sync_lvl = sync_reg[SYNC_STAGES-1];
   assign armed    = (arm_reg == ARM_DONE);

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_edge
      assign edge_det[gi] = armed & Enable[gi] &
                            (Rising[gi] ? (sync_lvl[gi] & ~hist_reg[gi])
                                        : (~sync_lvl[gi] & hist_reg[gi]));
   end

   assign fifo_pop = ~fifo_empty & Ready;
   assign space    = ~fifo_full | fifo_pop;

   // Fixed priority: lowest pending channel wins the single FIFO write slot.
   always_comb begin
      grant_oh  = '0;
      grant_any = 1'b0;
      wr_rec    = '0;
      if (space) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (pend_reg[i] && !grant_any) begin
               grant_oh[i]  = 1'b1;
               grant_any    = 1'b1;
               wr_rec.chan  = CHAN_FIELD_W'(i);
               wr_rec.stamp = stamp_reg[i];
            end
         end
      end
   end

   // A channel being drained this cycle may take a new edge; otherwise a pending one drops it.
   always_comb begin
      drop_vec  = edge_det & pend_reg & ~grant_oh;
      load_vec  = edge_det & ~drop_vec;
      pend_next = (pend_reg & ~grant_oh) | edge_det;
      drop_cnt  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         drop_cnt = drop_cnt + 5'(drop_vec[i]);
      end
   end

   always_comb begin
      ovf_sum = {1'b0, ovf_reg} + {12'b0, drop_cnt};
      if (ClrOvf)                      ovf_next = {11'b0, drop_cnt};
      else if (ovf_sum > {1'b0, OVF_MAX}) ovf_next = OVF_MAX;
      else                             ovf_next = ovf_sum[15:0];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pend_reg <= '0;
         ovf_reg  <= '0;
      end else begin
         pend_reg <= pend_next;
         ovf_reg  <= ovf_next;
      end
   end

   always_ff @(posedge Clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (load_vec[i]) stamp_reg[i] <= Timer;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(record_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (Clk),
      .srst  (Reset),
      .push  (grant_any),
      .din   (wr_rec),
      .pop   (fifo_pop),
      .dout  (head_rec),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (Level)
   );

   assign Valid    = ~fifo_empty;
   assign Stamp    = head_rec.stamp;
   assign Channel  = CH_W'(head_rec.chan);
   assign OvfCount = ovf_reg;

endmodule

// File: tb/tb_event_timestamper.sv
// Self-checking bench for event_timestamper: constant vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_event_timestamper;

   localparam int CH = 4;
   localparam int D  = 16;
   localparam int S  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] timer_v;
   logic [3:0]  ev, en, rise;
   logic        clr, rdy;
   logic        valid;
   logic [63:0] stamp;
   logic [1:0]  chan;
   logic [4:0]  level;
   logic [15:0] ovf;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   event_timestamper #(
      .CHANNELS    (CH),
      .FIFO_DEPTH  (D),
      .SYNC_STAGES (S)
   ) dut (
      .Clk      (clk),
      .Reset    (rst),
      .Timer    (timer_v),
      .Event    (ev),
      .Enable   (en),
      .Rising   (rise),
      .ClrOvf   (clr),
      .Ready    (rdy),
      .Valid    (valid),
      .Stamp    (stamp),
      .Channel  (chan),
      .Level    (level),
      .OvfCount (ovf)
   );

   // Reference model: pins seen S cycles late, pending slots per channel, FIFO as a queue.
   typedef struct {
      int          chan;
      logic [63:0] stamp;
   } rec_t;

   rec_t        m_fifo[$];
   logic [3:0]  m_log[$];
   logic [3:0]  m_hist;
   int          m_since;
   bit          m_pend[CH];
   logic [63:0] m_stamp[CH];
   int          m_ovf;

   task automatic model_step();
      logic [3:0] lvl;
      bit         edge_f[CH];
      bit         pop, space;
      int         g, nd;
      if (rst) begin
         m_fifo.delete();
         m_log.delete();
         m_hist  = '0;
         m_since = 0;
         m_ovf   = 0;
         for (int i = 0; i < CH; i++) m_pend[i] = 1'b0;
         return;
      end
      lvl = (m_log.size() >= S) ? m_log[S-1] : 4'b0;
      for (int i = 0; i < CH; i++)
         edge_f[i] = (m_since > S) && en[i] &&
                     (rise[i] ? (lvl[i] && !m_hist[i]) : (!lvl[i] && m_hist[i]));
      pop   = rdy && (m_fifo.size() > 0);
      space = (m_fifo.size() < D) || pop;
      g = -1;
      if (space)
         for (int i = 0; i < CH; i++)
            if (m_pend[i] && g < 0) g = i;
      nd = 0;
      for (int i = 0; i < CH; i++)
         if (edge_f[i] && m_pend[i] && i != g) nd++;
      m_ovf = clr ? nd : ((m_ovf + nd > 65535) ? 65535 : m_ovf + nd);
      if (pop) void'(m_fifo.pop_front());
      if (g >= 0) begin
         m_fifo.push_back('{g, m_stamp[g]});
         m_pend[g] = 1'b0;
      end
      for (int i = 0; i < CH; i++)
         if (edge_f[i] && !m_pend[i]) begin
            m_pend[i]  = 1'b1;
            m_stamp[i] = timer_v;
         end
      m_hist = lvl;
      m_log.push_front(ev);
      if (m_log.size() > S) void'(m_log.pop_back());
      if (m_since < 100) m_since++;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #2;
      timer_v = timer_v + 64'd20;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_cmp();
      chk("rnd_valid", 64'(valid), 64'(m_fifo.size() > 0));
      chk("rnd_level", 64'(level), 64'(m_fifo.size()));
      chk("rnd_ovf", 64'(ovf), 64'(m_ovf));
      if (m_fifo.size() > 0) begin
         chk("rnd_chan", 64'(chan), 64'(m_fifo[0].chan));
         chk("rnd_stamp", stamp, m_fifo[0].stamp);
      end
   endtask

   task automatic pulse0(input bit with_clr);
      for (int j = 0; j < 4; j++) begin
         ev[0] = (j < 2);
         clr   = with_clr && (j == 2);
         cycle();
      end
      clr = 1'b0;
   endtask

   typedef struct {
      logic [63:0] tmr;
      logic [3:0]  ev;
      bit          rdy;
      bit          exp_valid;
      int          exp_level;
      int          exp_chan;
      logic [63:0] exp_stamp;
   } vec_t;

   vec_t        vecs[12];
   logic [63:0] exp_q[$];
   logic [63:0] s_exp;
   int          pend_cnt;
   int          rdy_pct;

   initial begin
      #5ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Single rise on ch0 stamped at 1000, then ch1+ch3 together at 2000.
      vecs[0]  = '{64'd960,  4'b0001, 1'b0, 1'b0, 0, 0, 64'd0};
      vecs[1]  = '{64'd980,  4'b0001, 1'b0, 1'b0, 0, 0, 64'd0};
      vecs[2]  = '{64'd1000, 4'b0001, 1'b0, 1'b0, 0, 0, 64'd0};
      vecs[3]  = '{64'd1020, 4'b0001, 1'b0, 1'b1, 1, 0, 64'd1000};
      vecs[4]  = '{64'd1040, 4'b0001, 1'b1, 1'b0, 0, 0, 64'd0};
      vecs[5]  = '{64'd1060, 4'b0000, 1'b1, 1'b0, 0, 0, 64'd0};
      vecs[6]  = '{64'd1960, 4'b1010, 1'b1, 1'b0, 0, 0, 64'd0};
      vecs[7]  = '{64'd1980, 4'b1010, 1'b1, 1'b0, 0, 0, 64'd0};
      vecs[8]  = '{64'd2000, 4'b1010, 1'b1, 1'b0, 0, 0, 64'd0};
      vecs[9]  = '{64'd2020, 4'b1010, 1'b1, 1'b1, 1, 1, 64'd2000};
      vecs[10] = '{64'd2040, 4'b1010, 1'b1, 1'b1, 1, 3, 64'd2000};
      vecs[11] = '{64'd2060, 4'b1010, 1'b1, 1'b0, 0, 0, 64'd0};

      rst = 1'b1; ev = '0; en = 4'b1111; rise = 4'b1111;
      clr = 1'b0; rdy = 1'b0; timer_v = '0;
      cycle();
      cycle();
      chk("reset_valid", 64'(valid), 64'd0);
      chk("reset_level", 64'(level), 64'd0);
      chk("reset_ovf", 64'(ovf), 64'd0);
      chk("reset_stamp", stamp, 64'd0);
      chk("reset_chan", 64'(chan), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) cycle();

      for (int r = 0; r < 12; r++) begin
         timer_v = vecs[r].tmr;
         ev      = vecs[r].ev;
         rdy     = vecs[r].rdy;
         cycle();
         chk("vec_valid", 64'(valid), 64'(vecs[r].exp_valid));
         chk("vec_level", 64'(level), 64'(vecs[r].exp_level));
         if (vecs[r].exp_valid) begin
            chk("vec_chan", 64'(chan), 64'(vecs[r].exp_chan));
            chk("vec_stamp", stamp, vecs[r].exp_stamp);
         end
         $display("vec %0d: valid=%0d level=%0d chan=%0d stamp=%0d", r, valid, level, chan, stamp);
      end

      // Backpressure: 20 rises on ch0, 16 in FIFO, 1 pending, 3 dropped.
      ev = '0; en = 4'b0001; rdy = 1'b0;
      for (int n = 0; n < 20; n++)
         for (int j = 0; j < 4; j++) begin
            ev[0] = (j < 2);
            if (j == 2) exp_q.push_back(timer_v);
            cycle();
         end
      for (int i = 0; i < 4; i++) cycle();
      chk("full_level", 64'(level), 64'd16);
      chk("full_ovf", 64'(ovf), 64'd3);
      for (int k = 0; k < 17; k++) begin
         chk("drain_valid", 64'(valid), 64'd1);
         chk("drain_chan", 64'(chan), 64'd0);
         chk("drain_stamp", stamp, exp_q[k]);
         $display("drain %0d: chan=%0d stamp=%0d level=%0d", k, chan, stamp, level);
         rdy = 1'b1;
         cycle();
      end
      rdy = 1'b0;
      chk("drain_empty_valid", 64'(valid), 64'd0);
      chk("drain_empty_level", 64'(level), 64'd0);

      // Saturation: storm of drops on all channels, then single drops on ch0.
      en = 4'b1111; rise = 4'b1111; ev = '0;
      for (int c = 0; c < 20000 && m_ovf < 'hFFE0; c++) begin
         ev   = ~ev;
         rise = ev;
         cycle();
      end
      rise = 4'b1111; ev = '0;
      for (int i = 0; i < 6; i++) cycle();
      chk("storm_ovf", 64'(ovf), 64'(m_ovf));
      for (int p = 0; p < 100 && m_ovf < 'hFFFE; p++) pulse0(1'b0);
      chk("ovf_fffe", 64'(ovf), 64'hFFFE);
      for (int p = 0; p < 3; p++) pulse0(1'b0);
      chk("ovf_sat", 64'(ovf), 64'hFFFF);
      pulse0(1'b1);
      chk("ovf_clr_drop", 64'(ovf), 64'd1);
      $display("saturation: ovf=%0h", ovf);

      // Falling edge on a pin held high through reset.
      rst = 1'b1; ev = 4'b0100; rise = 4'b1011; en = 4'b1111; rdy = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      chk("arm_no_event_valid", 64'(valid), 64'd0);
      chk("arm_no_event_level", 64'(level), 64'd0);
      ev = '0;
      s_exp = '0;
      for (int j = 0; j < 5; j++) begin
         if (j == 2) s_exp = timer_v;
         cycle();
      end
      chk("fall_level", 64'(level), 64'd1);
      chk("fall_chan", 64'(chan), 64'd2);
      chk("fall_stamp", stamp, s_exp);
      $display("fall: chan=%0d stamp=%0d", chan, stamp);
      rdy = 1'b1;
      cycle();
      rdy = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      chk("fall_once", 64'(valid), 64'd0);

      // Reset with 5 records queued and 2 channels pending.
      rise = 4'b1111;
      ev = 4'b1111; cycle(); cycle();
      ev = 4'b0000; cycle(); cycle();
      ev = 4'b0111;
      for (int w = 0; w < 20; w++) begin
         pend_cnt = 0;
         for (int i = 0; i < CH; i++) pend_cnt += int'(m_pend[i]);
         if (m_fifo.size() == 5 && pend_cnt == 2) break;
         cycle();
      end
      chk("pre_reset_level", 64'(level), 64'd5);
      rst = 1'b1;
      cycle();
      chk("mid_reset_valid", 64'(valid), 64'd0);
      chk("mid_reset_level", 64'(level), 64'd0);
      chk("mid_reset_ovf", 64'(ovf), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("post_reset_quiet", 64'(valid), 64'd0);
      end

      // Randomized run against the model, crossing the Timer wrap.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      timer_v = 64'hFFFF_FFFF_FFFF_F000;
      rdy_pct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) rdy_pct = (c % 1500 == 0) ? 10 : ((c % 1000 == 0) ? 90 : 50);
         for (int i = 0; i < CH; i++)
            if ($urandom_range(3) == 0) ev[i] = ~ev[i];
         if ($urandom_range(63) == 0) en = 4'($urandom) | 4'b1001;
         if ($urandom_range(63) == 0) rise = 4'($urandom);
         rdy = ($urandom_range(99) < rdy_pct);
         clr = ($urandom_range(40) == 0);
         rst = ($urandom_range(700) == 0);
         cycle();
         model_cmp();
      end
      rst = 1'b0;
      clr = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
